// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, iteration count, funct3 encodings and FSM state encoding.

package muldiv_pkg;

  localparam int XLEN     = 32;
  localparam int ITER_CNT = 31;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix
// Combinational sign handling for the multiply/divide datapath.
//   abs_in/abs_signed -> abs_out/abs_neg : 32-bit magnitude and sign flag
//   neg_in/neg_en     -> neg_out         : 64-bit conditional two's-complement negate

module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0]   abs_in,
  input  logic              abs_signed,
  output logic [XLEN-1:0]   abs_out,
  output logic              abs_neg,
  input  logic [2*XLEN-1:0] neg_in,
  input  logic              neg_en,
  output logic [2*XLEN-1:0] neg_out
);

  assign abs_neg = abs_signed & abs_in[XLEN-1];
  assign abs_out = abs_neg ? (~abs_in + 1'b1) : abs_in;
  assign neg_out = neg_en ? (~neg_in + 1'b1) : neg_in;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit, one result bit per cycle.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : request handshake (ready only in IDLE)
//   funct3, rs1_val, rs2_val : operation and operands
//   rd_addr                  : destination tag, returned on out_rd_addr
//   flush                    : synchronous abort, wins over everything else
//   out_valid/out_ready      : result handshake, out_data/out_rd_addr
//   busy                     : high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for a request; in_ready=1
// ITER  | shift-add / restoring-divide step per cycle, counter running down
// DONE  | result presented, held until out_ready

module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd_addr,
  output logic            busy
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;

  // Request decode
  logic req_div, req_div_signed, a_signed, b_signed, sign_a, sign_b;
  logic div_zero, div_ovf, req_neg;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] mag_a64;

  assign req_div        = funct3[2];
  assign req_div_signed = req_div & ~funct3[0];
  assign a_signed       = (funct3 == F3_MULH) | (funct3 == F3_MULHSU) | req_div_signed;
  assign b_signed       = (funct3 == F3_MULH) | req_div_signed;
  assign sign_a         = a_signed & rs1_val[XLEN-1];

  // Negating the sign-extended rs1 yields |A| already zero-extended to 64 bits,
  // which is exactly the accumulator's starting value for both mul and div.
  muldiv_sign_fix u_fix_op (
    .abs_in     (rs2_val),
    .abs_signed (b_signed),
    .abs_out    (mag_b),
    .abs_neg    (sign_b),
    .neg_in     ({{XLEN{sign_a}}, rs1_val}),
    .neg_en     (sign_a),
    .neg_out    (mag_a64)
  );

  assign div_zero = req_div & (rs2_val == '0);
  assign div_ovf  = req_div_signed & (rs1_val == 32'h8000_0000) & (rs2_val == '1);
  // Remainder follows the dividend; a divide-by-zero quotient stays all ones.
  assign req_neg  = (req_div & funct3[1]) ? sign_a :
                    (div_zero ? 1'b0 : (sign_a ^ sign_b));

  // One iteration step. The accepting edge already performs the first step
  // straight from the operand magnitudes, so ITER needs only 31 more cycles.
  logic              it_idle, it_mul;
  logic [2*XLEN-1:0] it_acc;
  logic [XLEN-1:0]   it_b;
  logic [XLEN:0]     mul_sum, div_part;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] iter_next;

  assign it_idle  = (state_q == ST_IDLE);
  assign it_acc   = it_idle ? mag_a64 : acc_q;
  assign it_b     = it_idle ? mag_b : b_q;
  assign it_mul   = it_idle ? ~funct3[2] : ~f3_q[2];

  // Multiply: {hi, lo} with multiplier in lo, add into hi, shift right with carry.
  assign mul_sum  = {1'b0, it_acc[2*XLEN-1:XLEN]} + (it_acc[0] ? {1'b0, it_b} : '0);
  // Divide: shift the partial remainder left with the next dividend bit and
  // keep the subtraction when it does not go negative.
  assign div_part = it_acc[2*XLEN-1:XLEN-1];
  assign div_ge   = (div_part >= {1'b0, it_b});
  assign div_diff = div_part[XLEN-1:0] - it_b;
  assign iter_next = it_mul ? {mul_sum, it_acc[XLEN-1:1]} :
                     (div_ge ? {div_diff, it_acc[XLEN-2:0], 1'b1}
                             : {div_part[XLEN-1:0], it_acc[XLEN-2:0], 1'b0});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            b_d   = mag_b;
            f3_d  = funct3;
            rd_d  = rd_addr;
            neg_d = req_neg;
            if (div_zero) begin
              state_d = ST_DONE;
              acc_d   = {mag_a64[XLEN-1:0], {XLEN{1'b1}}};
            end else if (div_ovf) begin
              state_d = ST_DONE;
              acc_d   = {{XLEN{1'b0}}, 32'h8000_0000};
            end else begin
              state_d = ST_ITER;
              cnt_d   = 5'(ITER_CNT);
              acc_d   = iter_next;
            end
          end
        end
        ST_ITER: begin
          acc_d = iter_next;
          cnt_d = cnt_q - 5'd1;
          // Counter expires as it reaches zero; that step is the 32nd.
          if (cnt_q == 5'd1) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
    end
  end

  // Result: full product for multiplies, selected quotient/remainder for divides.
  logic [2*XLEN-1:0] res_sel, res_fixed;
  logic [XLEN-1:0]   unused_res_abs;
  logic              unused_res_abs_neg;

  assign res_sel = ~f3_q[2] ? acc_q
                 : {{XLEN{1'b0}}, (f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0])};

  muldiv_sign_fix u_fix_res (
    .abs_in     ('0),
    .abs_signed (1'b0),
    .abs_out    (unused_res_abs),
    .abs_neg    (unused_res_abs_neg),
    .neg_in     (res_sel),
    .neg_en     (neg_q),
    .neg_out    (res_fixed)
  );

  assign out_valid   = (state_q == ST_DONE);
  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = ~in_ready;
  assign out_rd_addr = rd_q;
  assign out_data    = ~out_valid ? '0 :
                       ((f3_q == F3_MUL) || f3_q[2]) ? res_fixed[XLEN-1:0]
                                                     : res_fixed[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, out_data;
  logic [4:0]  rd_addr, out_rd_addr;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .funct3      (funct3),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .rd_addr     (rd_addr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd_addr (out_rd_addr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      OP_MUL:    begin pu = ua * ub; return pu[31:0]; end
      OP_MULH:   begin ps = sa * sb; return ps[63:32]; end
      OP_MULHSU: begin ps = sa * longint'(ub); return ps[63:32]; end
      OP_MULHU:  begin pu = ua * ub; return pu[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        ps = sa / sb; return ps[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        ps = sa % sb; return ps[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  // Cycle (counted from the accepting edge) in which out_valid is first seen.
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3 >= OP_DIV && b == 0) return 1;
    if ((f3 == OP_DIV || f3 == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    check("in_ready_before_issue", in_ready, 1'b1);
    in_valid = 1'b1;
    funct3   = f3;
    rs1_val  = a;
    rs2_val  = b;
    rd_addr  = rd;
    @(posedge clk);
  endtask

  // Called right after the accepting edge.
  task automatic wait_result(input string tag, input logic [31:0] exp, input logic [4:0] rd,
                             input int lat_exp, input int hold);
    int lat;
    @(negedge clk);
    in_valid = 1'b0;
    rs1_val  = $urandom();
    rs2_val  = $urandom();
    rd_addr  = 5'($urandom());
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_data"}, out_data, exp);
    check({tag, "_rd"}, out_rd_addr, rd);
    check({tag, "_in_ready_done"}, in_ready, 1'b0);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "_hold_data"}, out_data, exp);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_after"}, out_valid, 1'b0);
    check({tag, "_in_ready_after"}, in_ready, 1'b1);
    check({tag, "_data_zero_after"}, out_data, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [4:0] rd;
    rd = 5'($urandom());
    issue(f3, a, b, rd);
    wait_result(tag, ref_result(f3, a, b), rd, ref_latency(f3, a, b), hold);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    logic        seen;

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    funct3 = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_rd", out_rd_addr, 5'd0);

    // First accept on the first edge after reset release: MUL 7 * -3.
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; funct3 = OP_MUL;
    rs1_val = 32'd7; rs2_val = 32'hFFFF_FFFD; rd_addr = 5'd9;
    @(posedge clk);
    wait_result("mul_7_m3", 32'hFFFF_FFEB, 5'd9, 32, 0);

    run_op("mulhu_ones", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulh_ones", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 0);
    run_op("remu_by0", OP_REMU, 32'd100, 32'd0, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Flush in ITER cycle 10 together with a new request.
    issue(OP_DIVU, 32'd1000, 32'd7, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_valid", out_valid, 1'b0);
    check("flush_pre_busy", busy, 1'b1);
    flush = 1'b1; in_valid = 1'b1; funct3 = OP_MULHU;
    rs1_val = 32'h1234_5678; rs2_val = 32'h9ABC_DEF0; rd_addr = 5'd17;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle_in_ready", in_ready, 1'b1);
    check("flush_idle_busy", busy, 1'b0);
    check("flush_no_valid", out_valid, 1'b0);
    @(posedge clk);
    wait_result("after_flush", ref_result(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 5'd17, 32, 0);

    // Asynchronous reset mid-ITER.
    issue(OP_MUL, 32'hDEAD_BEEF, 32'h0000_1234, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_release_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("rst_no_stale_valid", seen, 1'b0);
    run_op("mul_3_5", OP_MUL, 32'd3, 32'd5, 0);

    // rd 0 travels like any other tag.
    issue(OP_DIVU, 32'd99, 32'd10, 5'd0);
    wait_result("rd_zero", 32'd9, 5'd0, 32, 0);

    // Randomised operations against the reference.
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
